// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, drives IMEM, buffers {pc, inst} pairs for decode.
// Redirects flush the buffer; misaligned or out-of-range PCs raise a sticky fault.
//
//   state | meaning
//   RUN   | fetching one word per cycle whenever the buffer has room
//   FAULT | fetching stopped; buffered entries still drain to decode
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 1024,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {RUN, FAULT} state_t;

  state_t        state, state_nxt;
  logic [31:0]   pc, pc_nxt;
  logic          fault_nxt;
  logic [31:0]   fault_pc_nxt;
  logic          push, pop, flush;

  logic [31:0]   mem_pc   [FIFO_DEPTH];
  logic [31:0]   mem_inst [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  function automatic logic in_range(input logic [31:0] a);
    return {2'b00, a[31:2]} < 32'(IMEM_DEPTH);
  endfunction

  assign pop = if_valid & if_ready;

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    fault_nxt    = fault;
    fault_pc_nxt = fault_pc;
    push         = 1'b0;
    flush        = 1'b0;
    if (redirect_valid) begin
      flush  = 1'b1;
      pc_nxt = redirect_pc;
      if (redirect_pc[1:0] == 2'b00 && in_range(redirect_pc)) begin
        state_nxt = RUN;
        fault_nxt = 1'b0;
      end else begin
        state_nxt    = FAULT;
        fault_nxt    = 1'b1;
        fault_pc_nxt = redirect_pc;
      end
    end else begin
      case (state)
        RUN: begin
          if (in_range(pc)) begin
            if (count < DEPTH_C || pop) begin
              push   = 1'b1;
              pc_nxt = pc + 32'd4;
            end
          end else begin
            state_nxt    = FAULT;
            fault_nxt    = 1'b1;
            fault_pc_nxt = pc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      pc       <= RESET_PC;
      fault    <= 1'b0;
      fault_pc <= 32'd0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      fault    <= fault_nxt;
      fault_pc <= fault_pc_nxt;
    end
  end

  // Storage is reset too so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_pc[i]   <= 32'd0;
        mem_inst[i] <= 32'd0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_pc[wr_ptr]   <= pc;
        mem_inst[wr_ptr] <= imem_inst;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign imem_addr = pc;
  assign if_valid  = (count != '0);
  assign if_pc     = mem_pc[rd_ptr];
  assign if_inst   = mem_inst[rd_ptr];

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        fault;
  logic [31:0] fault_pc;

  int total = 0;
  int bad   = 0;

  logic [31:0] imem [1024];

  inst_fetch #(.RESET_PC(32'h0), .IMEM_DEPTH(1024), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
    .fault(fault), .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  assign imem_inst = imem[imem_addr[11:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buffer as a queue of {pc, inst}, capacity 2.
  logic [63:0] mq[$];
  logic [31:0] m_pc = 32'd0;
  logic        m_fault = 1'b0;
  logic [31:0] m_fault_pc = 32'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_pc = 32'd0;
      m_fault = 1'b0;
      m_fault_pc = 32'd0;
    end else begin
      bit pop_now;
      pop_now = (mq.size() != 0) && if_ready;
      if (redirect_valid) begin
        mq.delete();
        m_pc = redirect_pc;
        if (redirect_pc % 4 == 0 && (redirect_pc / 4) < 1024) m_fault = 1'b0;
        else begin
          m_fault = 1'b1;
          m_fault_pc = redirect_pc;
        end
      end else begin
        if (pop_now) void'(mq.pop_front());
        if (!m_fault) begin
          if ((m_pc / 4) < 1024) begin
            if (mq.size() < 2) begin
              mq.push_back({m_pc, imem[m_pc[11:2]]});
              m_pc = m_pc + 4;
            end
          end else begin
            m_fault = 1'b1;
            m_fault_pc = m_pc;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_valid", {31'd0, if_valid}, {31'd0, mq.size() != 0});
    if (mq.size() != 0) begin
      chk("model_if_pc", if_pc, mq[0][63:32]);
      chk("model_if_inst", if_inst, mq[0][31:0]);
    end
    chk("model_imem_addr", imem_addr, m_pc);
    chk("model_fault", {31'd0, fault}, {31'd0, m_fault});
    chk("model_fault_pc", fault_pc, m_fault_pc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = 32'hA500_0000 | i;
    imem[0]  = 32'h0000_0000;
    imem[1]  = 32'h0199_86B3;
    imem[2]  = 32'h4074_02B3;
    imem[11] = 32'h0094_8663;

    // reset state and steady streaming
    if_ready = 1'b1;
    #2;
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
    do_reset();
    tick(); chk("t1_pc0", if_pc, 32'h0);  chk("t1_inst0", if_inst, 32'h0000_0000);
    tick(); chk("t1_pc1", if_pc, 32'h4);  chk("t1_inst1", if_inst, 32'h0199_86B3);
    tick(); chk("t1_pc2", if_pc, 32'h8);  chk("t1_inst2", if_inst, 32'h4074_02B3);

    // backpressure
    if_ready = 1'b0;
    do_reset();
    repeat (5) tick();
    chk("t2_valid", {31'd0, if_valid}, 32'd1);
    chk("t2_addr_hold", imem_addr, 32'h8);
    chk("t2_pc_hold", if_pc, 32'h0);
    if_ready = 1'b1;
    tick(); chk("t2_pc1", if_pc, 32'h4);
    tick(); chk("t2_pc2", if_pc, 32'h8);

    // redirect on a full buffer
    if_ready = 1'b0;
    do_reset();
    tick(); tick();
    redirect(32'h2C);
    chk("t3_flush", {31'd0, if_valid}, 32'd0);
    tick();
    chk("t3_pc", if_pc, 32'h2C);
    chk("t3_inst", if_inst, 32'h0094_8663);

    // misaligned redirect then recovery
    redirect(32'h2E);
    chk("t4_fault", {31'd0, fault}, 32'd1);
    chk("t4_fault_pc", fault_pc, 32'h2E);
    chk("t4_valid", {31'd0, if_valid}, 32'd0);
    tick(); tick();
    chk("t4_valid_hold", {31'd0, if_valid}, 32'd0);
    if_ready = 1'b1;
    redirect(32'h0);
    chk("t4_clear", {31'd0, fault}, 32'd0);
    tick();
    chk("t4_resume", if_pc, 32'h0);

    // end of IMEM
    redirect(32'hFF8);
    tick(); chk("t5_pc0", if_pc, 32'hFF8);
    tick(); chk("t5_pc1", if_pc, 32'hFFC);
    tick();
    chk("t5_fault", {31'd0, fault}, 32'd1);
    chk("t5_fault_pc", fault_pc, 32'h1000);
    chk("t5_empty", {31'd0, if_valid}, 32'd0);
    tick(); tick();
    chk("t5_no_push", {31'd0, if_valid}, 32'd0);
    chk("t5_addr_hold", imem_addr, 32'h1000);

    // async reset mid-stream
    redirect(32'h0);
    if_ready = 1'b0;
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", {31'd0, if_valid}, 32'd0);
    chk("t6_async_addr", imem_addr, 32'h0);
    chk("t6_async_fault", {31'd0, fault}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    if_ready = 1'b1;
    tick(); chk("t6_restart0", if_pc, 32'h0);
    tick(); chk("t6_restart1", if_pc, 32'h4);

    // mixed traffic against the model only
    for (int i = 0; i < 60; i++) begin
      if_ready = $urandom_range(0, 1);
      if (i == 20) redirect(32'h40);
      else if (i == 35) redirect(32'h6);
      else if (i == 42) redirect(32'h10);
      else tick();
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
